// File: rtl/sha256_round_ctrl_if.sv
// Handshake and strobe bundle between the block feeder / hashing datapath
// and the SHA-256 round sequencer. The feeder side is the master: it
// raises start/abort and watches ready/busy/done. The datapath consumes
// the load/update/final strobes and the round index.
interface sha256_round_ctrl_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             load_init;
    logic [IDX_W-1:0] round_idx;
    logic             w_sel_msg;
    logic             w_shift;
    logic             state_we;
    logic             final_add;
    logic             done;

    modport master (
        output start, abort,
        input  ready, busy, load_init, round_idx, w_sel_msg,
               w_shift, state_we, final_add, done
    );

    modport slave (
        input  start, abort,
        output ready, busy, load_init, round_idx, w_sel_msg,
               w_shift, state_we, final_add, done
    );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer. Loads the initial hash state, walks the
// round counter through NUM_ROUNDS rounds of ROUND_CYCLES clocks each
// (the registered T1/T2 adders settle first, the working registers are
// written on the last clock of the round), then issues the final hash
// add and a one-cycle done pulse. Every output is a decode of the state
// register and the round/sub-round counters.
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS   = 64,
    parameter int ROUND_CYCLES = 2,
    parameter int IDX_W        = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sha256_round_ctrl_if.slave    bus
);

    // Sub-round counter wide enough for 0..ROUND_CYCLES-1.
    localparam int CW = (ROUND_CYCLES > 2) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [CW-1:0]    C_LAST    = CW'(ROUND_CYCLES - 1);
    localparam logic [IDX_W-1:0] R_LAST    = IDX_W'(NUM_ROUNDS - 1);
    // Rounds below this index take W straight from the message block.
    localparam logic [31:0]      MSG_WORDS = 32'd16;

    // A round needs one clock for the registered adders and one for the
    // write-back; fewer than two cannot work, so refuse to elaborate.
    if (ROUND_CYCLES < 2) begin : g_bad_round_cycles
        $error("sha256_round_ctrl: ROUND_CYCLES must be >= 2");
    end
    if ((1 << IDX_W) < NUM_ROUNDS) begin : g_bad_idx_w
        $error("sha256_round_ctrl: IDX_W too narrow for NUM_ROUNDS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] r, r_nx;
    logic [CW-1:0]    c, c_nx;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            r     <= '0;
            c     <= '0;
        end else begin
            state <= state_nx;
            r     <= r_nx;
            c     <= c_nx;
        end
    end

    // Next-state / counter update and Moore output decode.
    always_comb begin
        state_nx      = state;
        r_nx          = r;
        c_nx          = c;
        bus.ready     = 1'b0;
        bus.busy      = 1'b0;
        bus.load_init = 1'b0;
        bus.round_idx = '0;
        bus.w_sel_msg = 1'b0;
        bus.w_shift   = 1'b0;
        bus.state_we  = 1'b0;
        bus.final_add = 1'b0;
        bus.done      = 1'b0;

        case (state)
            S_IDLE: begin
                bus.ready = 1'b1;
                r_nx      = '0;
                c_nx      = '0;
                // abort alongside start cancels the request outright
                if (bus.start && !bus.abort) state_nx = S_INIT;
            end
            S_INIT: begin
                bus.busy      = 1'b1;
                bus.load_init = 1'b1;
                r_nx          = '0;
                c_nx          = '0;
                state_nx      = S_ROUND;
            end
            S_ROUND: begin
                bus.busy      = 1'b1;
                bus.round_idx = r;
                bus.w_sel_msg = (32'(r) < MSG_WORDS);
                if (c == C_LAST) begin
                    bus.state_we = 1'b1;
                    bus.w_shift  = 1'b1;
                    c_nx         = '0;
                    // last round: leave instead of wrapping r to 0 here
                    if (r == R_LAST) begin
                        r_nx     = '0;
                        state_nx = S_FINAL;
                    end else begin
                        r_nx = r + 1'b1;
                    end
                end else begin
                    c_nx = c + 1'b1;
                end
            end
            S_FINAL: begin
                bus.busy      = 1'b1;
                bus.final_add = 1'b1;
                state_nx      = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                r_nx     = '0;
                c_nx     = '0;
            end
        endcase

        // Cancel from any active state; the done pulse of the current
        // cycle is already on the wire and is left alone.
        if (bus.abort && state != S_IDLE) begin
            state_nx = S_IDLE;
            r_nx     = '0;
            c_nx     = '0;
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl at default parameters
// (64 rounds, 2 clocks per round).
module tb_sha256_round_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   we_cnt;
    int   sh_cnt;

    sha256_round_ctrl_if #(.IDX_W(6)) bus ();

    sha256_round_ctrl #(
        .NUM_ROUNDS  (64),
        .ROUND_CYCLES(2),
        .IDX_W       (6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs k cycles after the edge that sampled start:
    // INIT at k=1, rounds k=2..129 (two clocks each, write on the odd k),
    // FINAL at 130, DONE at 131, back to IDLE at 132.
    task automatic exp_check(input string tag, input int k);
        logic in_rnd;
        int   e_idx;
        in_rnd = (k >= 2) && (k <= 129);
        e_idx  = in_rnd ? (k - 2) / 2 : 0;
        chk1($sformatf("%s[%0d].ready", tag, k), bus.ready, k >= 132);
        chk1($sformatf("%s[%0d].busy", tag, k), bus.busy, (k >= 1) && (k <= 130));
        chk1($sformatf("%s[%0d].load_init", tag, k), bus.load_init, k == 1);
        chkn($sformatf("%s[%0d].round_idx", tag, k), int'(bus.round_idx), e_idx);
        chk1($sformatf("%s[%0d].w_sel_msg", tag, k), bus.w_sel_msg, in_rnd && (k <= 33));
        chk1($sformatf("%s[%0d].state_we", tag, k), bus.state_we, in_rnd && (k % 2 == 1));
        chk1($sformatf("%s[%0d].w_shift", tag, k), bus.w_shift, in_rnd && (k % 2 == 1));
        chk1($sformatf("%s[%0d].final_add", tag, k), bus.final_add, k == 130);
        chk1($sformatf("%s[%0d].done", tag, k), bus.done, k == 131);
    endtask

    // Caller raises start before the call; cycles 1..upto are checked.
    task automatic run_block(input string tag, input int upto, input bit hold);
        we_cnt = 0;
        sh_cnt = 0;
        for (int k = 1; k <= upto; k++) begin
            step();
            if (!hold) bus.start = 1'b0;
            if (bus.state_we) we_cnt++;
            if (bus.w_shift) sh_cnt++;
            exp_check(tag, k);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, ".ready"}, bus.ready, 1'b1);
        chk1({tag, ".busy"}, bus.busy, 1'b0);
        chk1({tag, ".load_init"}, bus.load_init, 1'b0);
        chkn({tag, ".round_idx"}, int'(bus.round_idx), 0);
        chk1({tag, ".state_we"}, bus.state_we, 1'b0);
        chk1({tag, ".w_shift"}, bus.w_shift, 1'b0);
        chk1({tag, ".w_sel_msg"}, bus.w_sel_msg, 1'b0);
        chk1({tag, ".final_add"}, bus.final_add, 1'b0);
        chk1({tag, ".done"}, bus.done, 1'b0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // reset state
        #2;
        chk_idle("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_idle("post_reset");

        // nominal block
        bus.start = 1'b1;
        run_block("nom", 132, 1'b0);
        chkn("nom.state_we_count", we_cnt, 64);
        chkn("nom.w_shift_count", sh_cnt, 64);

        // abort in round 40 (cycle 82), then a clean block
        bus.start = 1'b1;
        run_block("abt", 82, 1'b0);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk_idle("abt.after");
        for (int i = 0; i < 5; i++) begin
            step();
            chk_idle($sformatf("abt.quiet%0d", i));
        end
        bus.start = 1'b1;
        run_block("rerun", 132, 1'b0);
        chkn("rerun.state_we_count", we_cnt, 64);
        chkn("rerun.w_shift_count", sh_cnt, 64);

        // asynchronous reset in round 20, then 10 idle cycles
        bus.start = 1'b1;
        run_block("rst", 42, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst.async");
        step();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_idle($sformatf("rst.idle%0d", i));
        end

        // start held high: one block, next INIT right after ready
        bus.start = 1'b1;
        run_block("hold", 132, 1'b1);
        step();
        chk1("hold.second_init.load_init", bus.load_init, 1'b1);
        chk1("hold.second_init.busy", bus.busy, 1'b1);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk_idle("hold.aborted");

        // start and abort together in IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        chk_idle("sa.cyc1");
        step();
        chk_idle("sa.cyc2");
        bus.start = 1'b0;
        bus.abort = 1'b0;
        step();
        chk_idle("sa.cyc3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
